// File: rtl/score_transmitter.sv
// SPI-master (mode 0, MSB first) transmitter for per-lane hit results, fed by an event FIFO.
// Optional odd-parity 17th bit when SCORE_TX_PARITY_EN is defined.
module score_transmitter #(
  parameter int unsigned CLK_DIV    = 6,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CS_GAP     = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [3:0]                    hit_perfect,
  input  logic [3:0]                    hit_okay,
  input  logic [3:0]                    hit_miss,
  input  logic                          overflow_clr,
  output logic                          sck,
  output logic                          sdo,
  output logic                          cs_n,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned FRAME_W = 16;
`ifdef SCORE_TX_PARITY_EN
  localparam int unsigned NBITS   = FRAME_W + 1;
`else
  localparam int unsigned NBITS   = FRAME_W;
`endif
  localparam int unsigned DIV_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned DIV_W   = $clog2(DIV_MAX);
  localparam int unsigned BIT_W   = $clog2(NBITS);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [NBITS-1:0]     sr_q, sr_d;
  logic                 sck_q, sck_d;
  logic                 sdo_q, sdo_d;
  logic                 cs_n_q, cs_n_d;
  logic                 busy_q, busy_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FRAME_W-1:0]   mem [FIFO_DEPTH];

  logic [FRAME_W-1:0]   push_frame_c;
  logic [FRAME_W-1:0]   head_c;
  logic [NBITS-1:0]     head_ext_c;
  logic                 push_req_c;
  logic                 push_ok_c;
  logic                 pop_c;

  // FIFO bookkeeping; a pop in the same cycle frees room for a push into a full FIFO
  always_comb begin
    push_frame_c = {4'hA, hit_perfect, hit_okay, hit_miss};
    push_req_c   = |{hit_perfect, hit_okay, hit_miss};
    pop_c        = (state_q == IDLE) && (count_q != CNT_W'(0));
    push_ok_c    = push_req_c && ((count_q < CNT_W'(FIFO_DEPTH)) || pop_c);
    head_c       = mem[rd_ptr_q];
`ifdef SCORE_TX_PARITY_EN
    head_ext_c   = {head_c, ~^head_c};
`else
    head_ext_c   = head_c;
`endif
    count_d      = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
    wr_ptr_d     = wr_ptr_q + PTR_W'(push_ok_c);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop_c);
    overflow_d   = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (push_req_c && !push_ok_c) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr_q] <= push_frame_c;
  end

  // Frame sequencer: div_q paces SCK half-periods and the CS gap, bit_q counts falling edges
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    sck_d   = sck_q;
    sdo_d   = sdo_q;
    cs_n_d  = cs_n_q;
    unique case (state_q)
      IDLE: begin
        if (pop_c) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          sdo_d   = head_ext_c[NBITS-1];
          sr_d    = head_ext_c << 1;
          div_d   = DIV_W'(0);
          bit_d   = BIT_W'(0);
        end
      end
      SETUP: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d   = DIV_W'(0);
          sck_d   = 1'b1;
          state_d = SHIFT;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SHIFT: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = DIV_W'(0);
          if (sck_q) begin
            sck_d = 1'b0;
            if (bit_q == BIT_W'(NBITS - 1)) begin
              state_d = HOLD;
            end else begin
              sdo_d = sr_q[NBITS-1];
              sr_d  = sr_q << 1;
              bit_d = bit_q + BIT_W'(1);
            end
          end else begin
            sck_d = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      HOLD: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d   = DIV_W'(0);
          cs_n_d  = 1'b1;
          sdo_d   = 1'b0;
          state_d = GAP;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      GAP: begin
        if (div_q == DIV_W'(CS_GAP - 1)) begin
          div_d   = DIV_W'(0);
          state_d = IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sck_d   = 1'b0;
        sdo_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      sr_q       <= '0;
      sck_q      <= 1'b0;
      sdo_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sr_q       <= sr_d;
      sck_q      <= sck_d;
      sdo_q      <= sdo_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  assign sck        = sck_q;
  assign sdo        = sdo_q;
  assign cs_n       = cs_n_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_score_transmitter.sv
// Directed bench for score_transmitter: scoreboard of expected frames checked by an MCU-side SPI model.
module tb_score_transmitter;

  localparam int unsigned CLK_DIV    = 6;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned CS_GAP     = 4;
`ifdef SCORE_TX_PARITY_EN
  localparam int unsigned NB = 17;
`else
  localparam int unsigned NB = 16;
`endif
  localparam int unsigned LOW_EXP = (2 * NB + 1) * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] hit_perfect = '0;
  logic [3:0] hit_okay = '0;
  logic [3:0] hit_miss = '0;
  logic       overflow_clr = 1'b0;
  logic       sck, sdo, cs_n, busy, overflow;
  logic [3:0] fifo_count;
  logic [8:0] ov;

  int n_cmp = 0;
  int n_bad = 0;
  int n_frames = 0;
  int nbits = 0;
  int low_cnt = 0;
  int high_cnt = 0;
  bit seen_end = 1'b0;
  logic sck_prev = 1'b0;
  logic cs_prev = 1'b1;
  logic [NB-1:0] rx = '0;
  logic [NB-1:0] exp_q[$];

  score_transmitter #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .reset_n(reset_n),
    .hit_perfect(hit_perfect), .hit_okay(hit_okay), .hit_miss(hit_miss),
    .overflow_clr(overflow_clr),
    .sck(sck), .sdo(sdo), .cs_n(cs_n), .busy(busy), .overflow(overflow),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  assign ov = {cs_n, sck, sdo, busy, overflow, fifo_count};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] exp_frame(input logic [3:0] p, input logic [3:0] o,
                                              input logic [3:0] m);
    logic [15:0] f;
    f = {4'hA, p, o, m};
`ifdef SCORE_TX_PARITY_EN
    return {f, ~^f};
`else
    return f;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cs(input logic val, input int budget, input string tag);
    int k = 0;
    while (cs_n !== val && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(cs_n), 32'(val));
  endtask

  task automatic drain(input int budget, input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // MCU-side receiver: samples sdo on sck rises, checks frames and CS timing
  always @(negedge clk) begin
    if (!reset_n) begin
      nbits    = 0;
      low_cnt  = 0;
      high_cnt = 0;
      seen_end = 1'b0;
      sck_prev = sck;
      cs_prev  = cs_n;
    end else begin
      if (sck && !sck_prev) begin
        check("sck_rise_cs_low", 32'(cs_n), 32'd0);
        rx = {rx[NB-2:0], sdo};
        nbits++;
      end
      if (!cs_n && cs_prev) begin
        if (seen_end) check("cs_gap_min", 32'(high_cnt >= int'(CS_GAP + 1)), 32'd1);
        low_cnt = 1;
        nbits   = 0;
        rx      = '0;
      end else if (!cs_n) begin
        low_cnt++;
      end
      if (cs_n && !cs_prev) begin
        check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [NB-1:0] e;
          e = exp_q.pop_front();
          check("frame_data", 32'(rx), 32'(e));
        end
        check("frame_bits", 32'(nbits), 32'(NB));
        check("cs_low_len", 32'(low_cnt), 32'(LOW_EXP));
        n_frames++;
        seen_end = 1'b1;
        high_cnt = 1;
      end else if (cs_n) begin
        high_cnt++;
      end
      sck_prev = sck;
      cs_prev  = cs_n;
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f0;
    #1 reset_n = 1'b0;
    step();
    check("reset_state", 32'(ov), 32'h100);
    step();
    reset_n = 1'b1;
    step();

    // idle, no hits
    for (int i = 0; i < 500; i++) begin
      step();
      check("idle_outputs", 32'(ov), 32'h100);
    end

    // single hit: latency, frame content, busy after the gap
    f0 = n_frames;
    hit_perfect = 4'b0001;
    hit_miss    = 4'b0100;
    exp_q.push_back(exp_frame(4'b0001, 4'b0000, 4'b0100));
    step();
    hit_perfect = '0;
    hit_miss    = '0;
    check("lat_e1_cs_n", 32'(cs_n), 32'd1);
    check("lat_e1_count", 32'(fifo_count), 32'd1);
    step();
    check("lat_e2_cs_n", 32'(cs_n), 32'd0);
    check("lat_e2_busy", 32'(busy), 32'd1);
    check("lat_e2_count", 32'(fifo_count), 32'd0);
    wait_cs(1'b1, 400, "single_cs_rise");
    check("single_sdo_after", 32'(sdo), 32'd0);
    repeat (CS_GAP - 1) step();
    check("busy_end_gap", 32'(busy), 32'd1);
    step();
    check("busy_idle", 32'(busy), 32'd0);
    check("single_frames", 32'(n_frames - f0), 32'd1);

    // overflow: 10 back-to-back hits, 9 accepted
    f0 = n_frames;
    step();
    for (int i = 0; i < 10; i++) begin
      hit_okay = 4'b1000;
      if (i < 9) exp_q.push_back(exp_frame(4'b0000, 4'b1000, 4'b0000));
      if (i == 9) check("ovf_before_drop", 32'(overflow), 32'd0);
      step();
    end
    hit_okay = '0;
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count_full", 32'(fifo_count), 32'd8);
    drain(5000, "ovf_drain");
    check("ovf_frames", 32'(n_frames - f0), 32'd9);
    check("ovf_sticky", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // reset mid-frame
    f0 = n_frames;
    step();
    for (int i = 0; i < 3; i++) begin
      hit_perfect = 4'(i + 1);
      step();
    end
    hit_perfect = '0;
    begin
      int k = 0;
      while (nbits < 5 && k < 300) begin
        step();
        k++;
      end
    end
    check("mid_sck_high", 32'(sck), 32'd1);
    check("mid_count", 32'(fifo_count), 32'd2);
    reset_n = 1'b0;
    #1;
    check("mid_reset_outputs", 32'(ov), 32'h100);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("post_reset_count", 32'(fifo_count), 32'd0);
    repeat (300) step();
    check("post_reset_idle", 32'(ov), 32'h100);
    check("post_reset_frames", 32'(n_frames - f0), 32'd0);

    // push/pop collision on the pop cycle with a full FIFO
    f0 = n_frames;
    step();
    for (int i = 0; i < 9; i++) begin
      hit_perfect = 4'(i + 1);
      hit_miss    = 4'(8 - i);
      exp_q.push_back(exp_frame(4'(i + 1), 4'b0000, 4'(8 - i)));
      step();
    end
    hit_perfect = '0;
    hit_miss    = '0;
    check("col_full_count", 32'(fifo_count), 32'd8);
    check("col_no_ovf", 32'(overflow), 32'd0);
    wait_cs(1'b1, 400, "col_cs_rise");
    repeat (CS_GAP) step();
    check("col_pop_idle", 32'({cs_n, busy}), 32'b10);
    check("col_pop_count", 32'(fifo_count), 32'd8);
    hit_okay = 4'b0110;
    exp_q.push_back(exp_frame(4'b0000, 4'b0110, 4'b0000));
    step();
    hit_okay = '0;
    check("col_count_kept", 32'(fifo_count), 32'd8);
    check("col_ovf_kept", 32'(overflow), 32'd0);
    check("col_cs_fell", 32'(cs_n), 32'd0);
    drain(5000, "col_drain");
    check("col_frames", 32'(n_frames - f0), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
